serial_frame_feeder: RTL and testbench

//  Transmit side of the 12-bit serial accumulator interface (n/enable). Collects samples

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/frame_pingpong_buf.sv | 59 +++++
 rtl/serial_frame_feeder.sv | 107 ++++++++++
 tb/tb_serial_frame_feeder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared constants and FSM state type for the serial accumulator interface.
package serial_adder_pkg;

    localparam int unsigned DATA_W      = 12;
    localparam int unsigned FRAME_LEN   = 8;
    localparam int unsigned SUM_W       = 15;
    localparam int unsigned FRAME_IDX_W = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        GAP
    } feeder_state_e;

endpackage

// File: rtl/frame_pingpong_buf.sv
// Two-bank frame store: fills banks in turn from the write port, exposes a read port
// addressed by (bank, index) and per-bank full flags released by the reader.
module frame_pingpong_buf
    import serial_adder_pkg::*;
#(
    parameter int unsigned DataW    = DATA_W,
    parameter int unsigned FrameLen = FRAME_LEN
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en_i,
    input  logic [DataW-1:0]            wr_data_i,
    output logic                        wr_ready_o,
    input  logic                        rel_i,
    input  logic                        rd_bank_i,
    input  logic [$clog2(FrameLen)-1:0] rd_idx_i,
    output logic [DataW-1:0]            rd_data_o,
    output logic [1:0]                  full_o
);

    localparam int unsigned IdxW = $clog2(FrameLen);

    logic [DataW-1:0] mem_q [2][FrameLen];
    logic [1:0]       full_q;
    logic             wr_bank_q;
    logic [IdxW-1:0]  wr_idx_q;

    assign wr_ready_o = !full_q[wr_bank_q];
    assign rd_data_o  = mem_q[rd_bank_i][rd_idx_i];
    assign full_o     = full_q;

    // Set and clear never hit the same bank: the reader only releases a full bank,
    // while the writer is always filling a non-full one.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            wr_idx_q  <= '0;
        end else begin
            if (wr_en_i) begin
                wr_idx_q <= wr_idx_q + 1'b1;
                if (wr_idx_q == IdxW'(FrameLen - 1)) begin
                    full_q[wr_bank_q] <= 1'b1;
                    wr_bank_q         <= ~wr_bank_q;
                end
            end
            if (rel_i) begin
                full_q[rd_bank_i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_bank_q][wr_idx_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/serial_frame_feeder.sv
// Buffers producer samples into ping-pong frames and streams each full frame on n with
// enable high for exactly FRAME_LEN cycles, followed by GAP_CYCLES of enable low.
module serial_frame_feeder
    import serial_adder_pkg::*;
#(
    parameter int unsigned DATA_W     = serial_adder_pkg::DATA_W,
    parameter int unsigned FRAME_LEN  = serial_adder_pkg::FRAME_LEN,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [DATA_W-1:0] n,
    output logic              enable,
    output logic              frame_start,
    output logic              frame_last,
    output logic              busy
);

    localparam int unsigned IdxW = $clog2(FRAME_LEN);
    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    feeder_state_e     state_q;
    logic              rd_bank_q;
    logic [IdxW-1:0]   rd_idx_q;
    logic [GapW-1:0]   gap_cnt_q;
    logic              wr_en;
    logic              rel;
    logic [DATA_W-1:0] rd_data;
    logic [1:0]        full;

    assign wr_en = wr_valid && wr_ready;
    assign rel   = (state_q == STREAM) && (rd_idx_q == IdxW'(FRAME_LEN - 1));
    assign busy  = (|full) || (state_q != IDLE);

    frame_pingpong_buf #(
        .DataW    (DATA_W),
        .FrameLen (FRAME_LEN)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (wr_en),
        .wr_data_i  (wr_data),
        .wr_ready_o (wr_ready),
        .rel_i      (rel),
        .rd_bank_i  (rd_bank_q),
        .rd_idx_i   (rd_idx_q),
        .rd_data_o  (rd_data),
        .full_o     (full)
    );

    // IDLE emits sample 0 on the same edge it leaves, so a frame full at edge E is on n
    // after E+1 and STREAM only has to supply the remaining FRAME_LEN-1 samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_bank_q   <= 1'b0;
            rd_idx_q    <= '0;
            gap_cnt_q   <= '0;
            n           <= '0;
            enable      <= 1'b0;
            frame_start <= 1'b0;
            frame_last  <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            frame_last  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (full[rd_bank_q]) begin
                        n           <= rd_data;
                        enable      <= 1'b1;
                        frame_start <= 1'b1;
                        rd_idx_q    <= rd_idx_q + 1'b1;
                        state_q     <= STREAM;
                    end else begin
                        n      <= '0;
                        enable <= 1'b0;
                    end
                end
                STREAM: begin
                    n        <= rd_data;
                    enable   <= 1'b1;
                    rd_idx_q <= rd_idx_q + 1'b1;
                    if (rel) begin
                        frame_last <= 1'b1;
                        rd_bank_q  <= ~rd_bank_q;
                        gap_cnt_q  <= '0;
                        state_q    <= GAP;
                    end
                end
                GAP: begin
                    n      <= '0;
                    enable <= 1'b0;
                    if (gap_cnt_q == GapW'(GAP_CYCLES - 1)) begin
                        state_q <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_feeder.sv
// Directed bench for serial_frame_feeder with a behavioural accumulator on n/enable.
module tb_serial_frame_feeder;

    logic        clk;
    logic        rst;
    logic        wr_valid;
    logic [11:0] wr_data;
    logic        wr_ready;
    logic [11:0] n;
    logic        enable;
    logic        frame_start;
    logic        frame_last;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    serial_frame_feeder dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .n           (n),
        .enable      (enable),
        .frame_start (frame_start),
        .frame_last  (frame_last),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor state: observed samples, enable run/gap lengths and accumulator results.
    logic [11:0] obs_q[$];
    logic [11:0] start_q[$];
    logic [11:0] last_q[$];
    logic [14:0] res_q[$];
    int          runs_q[$];
    int          gaps_q[$];
    int          run_len   = 0;
    int          gap_len   = 0;
    int          stall_cnt = 0;
    bit          seen_run  = 1'b0;
    logic [14:0] acc       = '0;

    initial forever begin
        @(negedge clk);
        if (wr_valid && !wr_ready) stall_cnt++;
        if (enable) begin
            if (run_len == 0 && seen_run) gaps_q.push_back(gap_len);
            obs_q.push_back(n);
            run_len++;
            acc = acc + {{3{n[11]}}, n};
            if (frame_last) begin
                res_q.push_back(acc);
                acc = '0;
            end
        end else begin
            if (run_len != 0) begin
                runs_q.push_back(run_len);
                run_len  = 0;
                seen_run = 1'b1;
                gap_len  = 0;
            end
            gap_len++;
        end
        if (frame_start) start_q.push_back(n);
        if (frame_last) last_q.push_back(n);
    end

    initial begin
        #300000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        obs_q.delete();
        start_q.delete();
        last_q.delete();
        res_q.delete();
        runs_q.delete();
        gaps_q.delete();
        run_len   = 0;
        gap_len   = 0;
        stall_cnt = 0;
        seen_run  = 1'b0;
        acc       = '0;
    endtask

    // Leaves wr_valid high after the accepting edge; callers end a burst with idle().
    task automatic write_sample(input logic [11:0] d);
        int w = 0;
        tick();
        wr_valid = 1'b1;
        wr_data  = d;
        while (!wr_ready && w < 200) begin
            tick();
            w++;
        end
        chk("wr_accept", {31'd0, wr_ready}, 32'd1);
        @(posedge clk);
    endtask

    task automatic idle();
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_results(input int k);
        int w = 0;
        while (res_q.size() < k && w < 400) begin
            tick();
            w++;
        end
        chk("frames_done", res_q.size(), k);
        repeat (4) tick();
    endtask

    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
        repeat (3) tick();
        chk("rst_n", {20'd0, n}, 32'd0);
        chk("rst_enable", {31'd0, enable}, 32'd0);
        chk("rst_frame_start", {31'd0, frame_start}, 32'd0);
        chk("rst_frame_last", {31'd0, frame_last}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        rst = 1'b0;
        repeat (2) tick();
        clear();

        // 1: samples 1..8 back to back
        for (int i = 1; i <= 8; i++) write_sample(12'(i));
        idle();
        wait_results(1);
        chk("t1_runs", runs_q.size(), 1);
        chk("t1_run_len", runs_q[0], 8);
        chk("t1_n3", {20'd0, obs_q[3]}, 32'd4);
        chk("t1_starts", start_q.size(), 1);
        chk("t1_start_n", {20'd0, start_q[0]}, 32'd1);
        chk("t1_last_n", {20'd0, last_q[0]}, 32'd8);
        chk("t1_sum", {17'd0, res_q[0]}, 32'd36);
        chk("t1_busy_after", {31'd0, busy}, 32'd0);
        clear();

        // 2: most negative sample eight times
        for (int i = 0; i < 8; i++) write_sample(12'h800);
        idle();
        wait_results(1);
        chk("t2_n0", {20'd0, obs_q[0]}, 32'h800);
        chk("t2_n7", {20'd0, obs_q[7]}, 32'h800);
        chk("t2_run_len", runs_q[0], 8);
        chk("t2_sum", {17'd0, res_q[0]}, 32'h4000);
        clear();

        // 3: sixteen samples, two frames, one-cycle gap
        for (int i = 1; i <= 16; i++) write_sample(12'(i));
        idle();
        wait_results(2);
        chk("t3_runs", runs_q.size(), 2);
        chk("t3_run1", runs_q[1], 8);
        chk("t3_gaps", gaps_q.size(), 1);
        chk("t3_gap_len", gaps_q[0], 1);
        chk("t3_sum0", {17'd0, res_q[0]}, 32'd36);
        chk("t3_sum1", {17'd0, res_q[1]}, 32'd100);
        clear();

        // 4: 24 samples with wr_valid held; both banks full right after the 24th write
        for (int i = 1; i <= 24; i++) write_sample(12'(i));
        tick();
        chk("t4_ready_low", {31'd0, wr_ready}, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd1);
        wr_valid = 1'b0;
        tick();
        chk("t4_ready_back", {31'd0, wr_ready}, 32'd1);
        chk("t4_last_with_ready", {31'd0, frame_last}, 32'd1);
        wait_results(3);
        chk("t4_stalls", stall_cnt, 1);
        chk("t4_count", obs_q.size(), 24);
        for (int i = 0; i < 24; i++) chk("t4_order", {20'd0, obs_q[i]}, 32'(i + 1));
        chk("t4_sum2", {17'd0, res_q[2]}, 32'd164);
        chk("t4_gap_a", gaps_q[0], 1);
        chk("t4_gap_b", gaps_q[1], 1);
        clear();

        // 5: producer valid every other cycle, max positive sample
        for (int i = 0; i < 7; i++) begin
            write_sample(12'h7FF);
            idle();
        end
        chk("t5_no_early_enable", {31'd0, enable}, 32'd0);
        chk("t5_no_early_obs", obs_q.size(), 0);
        write_sample(12'h7FF);
        idle();
        wait_results(1);
        chk("t5_runs", runs_q.size(), 1);
        chk("t5_run_len", runs_q[0], 8);
        chk("t5_sum", {17'd0, res_q[0]}, 32'h3FF8);
        clear();

        // 6: reset while the 4th sample is on n
        for (int i = 1; i <= 8; i++) write_sample(12'(i));
        idle();
        begin
            int w = 0;
            while (obs_q.size() < 4 && w < 100) begin
                tick();
                w++;
            end
        end
        chk("t6_n_before_rst", {20'd0, n}, 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_enable", {31'd0, enable}, 32'd0);
        chk("t6_n", {20'd0, n}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_wr_ready", {31'd0, wr_ready}, 32'd1);
        clear();
        for (int i = 21; i <= 25; i++) write_sample(12'(i));
        idle();
        repeat (30) tick();
        chk("t6_no_partial", obs_q.size(), 0);
        for (int i = 26; i <= 28; i++) write_sample(12'(i));
        idle();
        wait_results(1);
        chk("t6_count", obs_q.size(), 8);
        chk("t6_start_n", {20'd0, start_q[0]}, 32'd21);
        chk("t6_sum", {17'd0, res_q[0]}, 32'd196);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
